dram_cmd_responder: RTL and testbench

- Device-side end of the controller command interface: accepts cmd_req/cmd with one-hot bank/row/col selects and answers with cmd_ack on a 4-phase handshake.
- Tracks the open row per bank, enforces per-command latencies and holds a 1-bit-per-location storage array.
- Replaces the behavioural ack model and the DRAM BFM as the synthesizable target the controller talks to.

---
 rtl/dram_cmd_responder_if.sv | 40 ++++
 rtl/dram_cmd_responder.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_dram_cmd_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dram_cmd_responder_if.sv
// Command interface between a DRAM controller (master) and the device-side
// responder (slave).
//
// Signals:
//   cmd_req      master -> slave  4-phase command request
//   cmd          master -> slave  00 ACTIVATE, 01 READ, 10 WRITE, 11 PRECHARGE
//   bank_sel     master -> slave  one-hot bank select
//   row_sel      master -> slave  one-hot row select (ACTIVATE)
//   col_sel      master -> slave  one-hot column select (READ/WRITE)
//   wr_data      master -> slave  write bit
//   cmd_ack      slave -> master  command complete
//   rd_data      slave -> master  read bit
//   cmd_err      slave -> master  command rejected, valid with cmd_ack
//   refresh_busy slave -> master  refresh in progress
interface dram_cmd_responder_if #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8
);
    logic                    cmd_req;
    logic [1:0]              cmd;
    logic [NUM_OF_BANKS-1:0] bank_sel;
    logic [NUM_OF_ROWS-1:0]  row_sel;
    logic [NUM_OF_COLS-1:0]  col_sel;
    logic                    wr_data;
    logic                    cmd_ack;
    logic                    rd_data;
    logic                    cmd_err;
    logic                    refresh_busy;

    modport master (
        output cmd_req, cmd, bank_sel, row_sel, col_sel, wr_data,
        input  cmd_ack, rd_data, cmd_err, refresh_busy
    );

    modport slave (
        input  cmd_req, cmd, bank_sel, row_sel, col_sel, wr_data,
        output cmd_ack, rd_data, cmd_err, refresh_busy
    );
endinterface

// File: rtl/dram_cmd_responder.sv
// Device-side responder for the DRAM controller command interface.
// Accepts one command at a time on a 4-phase req/ack handshake, tracks the
// open row of every bank, applies per-command latencies and holds a
// 1-bit-per-location storage array.
//
// Ports:
//   clk    rising-edge clock
//   rst_b  asynchronous active-low reset (released synchronously upstream)
//   bus    dram_cmd_responder_if.slave command interface
//
// Build option:
//   DRAM_REFRESH_EN  when defined, a free-running counter issues a refresh
//                    every REFRESH_INTERVAL cycles; while refresh_busy is
//                    high all banks are closed and commands are held off.
//                    When undefined refresh_busy is tied low.
module dram_cmd_responder #(
    parameter int NUM_OF_BANKS     = 8,
    parameter int NUM_OF_ROWS      = 128,
    parameter int NUM_OF_COLS      = 8,
    parameter int T_RCD            = 3,
    parameter int T_CL             = 2,
    parameter int T_WR             = 2,
    parameter int T_RP             = 3,
    parameter int REFRESH_INTERVAL = 512,
    parameter int T_RFC            = 8
) (
    input  logic                  clk,
    input  logic                  rst_b,
    dram_cmd_responder_if.slave   bus
);
    localparam int BANK_W = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
    localparam int ROW_W  = (NUM_OF_ROWS  > 1) ? $clog2(NUM_OF_ROWS)  : 1;
    localparam int COL_W  = (NUM_OF_COLS  > 1) ? $clog2(NUM_OF_COLS)  : 1;
    localparam int DEPTH  = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = 8;

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK, S_RELEASE} state_t;

    state_t                  state_q, state_d;
    logic                    dec_pend_q, dec_pend_d;   // first BUSY cycle decodes
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              cmd_q, cmd_d;
    logic [NUM_OF_BANKS-1:0] bank_q, bank_d;
    logic [NUM_OF_ROWS-1:0]  row_q, row_d;
    logic [NUM_OF_COLS-1:0]  col_q, col_d;
    logic                    wdat_q, wdat_d;
    logic                    bad_q, bad_d;             // latched decode error
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    rd_q, rd_d;
    logic [NUM_OF_BANKS-1:0] open_q, open_d;
    logic [ROW_W-1:0]        open_row_q [NUM_OF_BANKS];
    logic [ROW_W-1:0]        open_row_d [NUM_OF_BANKS];

`ifdef DRAM_REFRESH_EN
    localparam int RI_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    logic [RI_W-1:0]  rint_q, rint_d;
    logic             rpend_q, rpend_d;
    logic             rbusy_q, rbusy_d;
    logic [CNT_W-1:0] rfc_q, rfc_d;
    logic             rpend_clr;
`endif

    // One-hot to index of the latched selects; non-one-hot values are
    // flagged as errors before the index is ever used.
    logic [BANK_W-1:0] bank_idx;
    logic [ROW_W-1:0]  row_idx;
    logic [COL_W-1:0]  col_idx;

    always_comb begin
        bank_idx = '0;
        for (int i = 0; i < NUM_OF_BANKS; i++)
            if (bank_q[i]) bank_idx = bank_idx | BANK_W'(i);
    end

    always_comb begin
        row_idx = '0;
        for (int i = 0; i < NUM_OF_ROWS; i++)
            if (row_q[i]) row_idx = row_idx | ROW_W'(i);
    end

    always_comb begin
        col_idx = '0;
        for (int i = 0; i < NUM_OF_COLS; i++)
            if (col_q[i]) col_idx = col_idx | COL_W'(i);
    end

    logic             bank_ok, row_ok, col_ok, bank_open;
    logic             dec_bad;
    logic [CNT_W-1:0] dec_lat;

    assign bank_ok   = $onehot(bank_q);
    assign row_ok    = $onehot(row_q);
    assign col_ok    = $onehot(col_q);
    assign bank_open = open_q[bank_idx];

    always_comb begin
        dec_bad = 1'b0;
        dec_lat = '0;
        case (cmd_q)
            CMD_ACT: begin
                dec_bad = !bank_ok || !row_ok || bank_open;
                dec_lat = CNT_W'(T_RCD - 1);
            end
            CMD_RD: begin
                dec_bad = !bank_ok || !col_ok || !bank_open;
                dec_lat = CNT_W'(T_CL - 1);
            end
            CMD_WR: begin
                dec_bad = !bank_ok || !col_ok || !bank_open;
                dec_lat = CNT_W'(T_WR - 1);
            end
            default: begin
                // PRECHARGE of a closed bank is a harmless no-op
                dec_bad = !bank_ok;
                dec_lat = CNT_W'(T_RP - 1);
            end
        endcase
    end

    // Storage array: no reset, registered read. The address only depends on
    // latched operands and the open row, both stable for the whole command,
    // so mem_rd_q is valid by the time the READ completes.
    logic                mem [DEPTH];
    logic                mem_rd_q;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;

    assign mem_addr = ADDR_W'(bank_idx) * ADDR_W'(NUM_OF_ROWS * NUM_OF_COLS)
                    + ADDR_W'(open_row_q[bank_idx]) * ADDR_W'(NUM_OF_COLS)
                    + ADDR_W'(col_idx);

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= wdat_q;
        mem_rd_q <= mem[mem_addr];
    end

    always_comb begin
        state_d    = state_q;
        dec_pend_d = dec_pend_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        bank_d     = bank_q;
        row_d      = row_q;
        col_d      = col_q;
        wdat_d     = wdat_q;
        bad_d      = bad_q;
        ack_d      = ack_q;
        err_d      = err_q;
        rd_d       = rd_q;
        open_d     = open_q;
        open_row_d = open_row_q;
        mem_we     = 1'b0;
`ifdef DRAM_REFRESH_EN
        rbusy_d    = rbusy_q;
        rfc_d      = rfc_q;
        rpend_clr  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                ack_d = 1'b0;
                err_d = 1'b0;
`ifdef DRAM_REFRESH_EN
                // Refresh wins over a same-cycle request; requests wait
                // until refresh_busy has dropped.
                if (rbusy_q) begin
                    if (rfc_q == '0) rbusy_d = 1'b0;
                    else             rfc_d   = rfc_q - 1'b1;
                end else if (rpend_q) begin
                    rpend_clr = 1'b1;
                    rbusy_d   = 1'b1;
                    rfc_d     = CNT_W'(T_RFC - 1);
                    open_d    = '0;
                end else
`endif
                if (bus.cmd_req) begin
                    cmd_d      = bus.cmd;
                    bank_d     = bus.bank_sel;
                    row_d      = bus.row_sel;
                    col_d      = bus.col_sel;
                    wdat_d     = bus.wr_data;
                    dec_pend_d = 1'b1;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (dec_pend_q) begin
                    dec_pend_d = 1'b0;
                    bad_d      = dec_bad;
                    cnt_d      = dec_bad ? '0 : dec_lat;
                end else if (cnt_q == '0) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    err_d   = bad_q;
                    if (!bad_q) begin
                        case (cmd_q)
                            CMD_ACT: begin
                                open_d[bank_idx]     = 1'b1;
                                open_row_d[bank_idx] = row_idx;
                            end
                            CMD_RD:  rd_d   = mem_rd_q;
                            CMD_WR:  mem_we = 1'b1;
                            default: open_d[bank_idx] = 1'b0;
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACK: begin
                // A request already low here still yields a one-cycle ack
                if (!bus.cmd_req) begin
                    state_d = S_RELEASE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
                err_d   = 1'b0;
            end
        endcase
`ifdef DRAM_REFRESH_EN
        // A new request raised this cycle survives the clear of the old one
        if (rint_q == RI_W'(REFRESH_INTERVAL - 1)) begin
            rint_d  = '0;
            rpend_d = 1'b1;
        end else begin
            rint_d  = rint_q + 1'b1;
            rpend_d = rpend_clr ? 1'b0 : rpend_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            dec_pend_q <= 1'b0;
            cnt_q      <= '0;
            cmd_q      <= '0;
            bank_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            wdat_q     <= 1'b0;
            bad_q      <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_q       <= 1'b0;
            open_q     <= '0;
            for (int i = 0; i < NUM_OF_BANKS; i++) open_row_q[i] <= '0;
`ifdef DRAM_REFRESH_EN
            rint_q     <= '0;
            rpend_q    <= 1'b0;
            rbusy_q    <= 1'b0;
            rfc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            dec_pend_q <= dec_pend_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            bank_q     <= bank_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wdat_q     <= wdat_d;
            bad_q      <= bad_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rd_q       <= rd_d;
            open_q     <= open_d;
            open_row_q <= open_row_d;
`ifdef DRAM_REFRESH_EN
            rint_q     <= rint_d;
            rpend_q    <= rpend_d;
            rbusy_q    <= rbusy_d;
            rfc_q      <= rfc_d;
`endif
        end
    end

    assign bus.cmd_ack = ack_q;
    assign bus.rd_data = rd_q;
    assign bus.cmd_err = err_q;
`ifdef DRAM_REFRESH_EN
    assign bus.refresh_busy = rbusy_q;
`else
    // Refresh timing parameters have no effect in this build
    localparam bit REFRESH_CFG_VALID = (REFRESH_INTERVAL > 0) && (T_RFC > 0);
    assign bus.refresh_busy = 1'b0 && REFRESH_CFG_VALID;
`endif
endmodule

// File: tb/tb_dram_cmd_responder.sv
module tb_dram_cmd_responder;
`ifdef DRAM_REFRESH_EN
    localparam int RI = 16;
`else
    localparam int RI = 512;
`endif
    localparam logic [1:0] ACT = 2'b00, RD = 2'b01, WR = 2'b10, PRE = 2'b11;

    logic clk;
    logic rst_b;
    int   n_chk = 0;
    int   n_bad = 0;

    dram_cmd_responder_if #(.NUM_OF_BANKS(8), .NUM_OF_ROWS(128), .NUM_OF_COLS(8)) bus();

    dram_cmd_responder #(
        .NUM_OF_BANKS(8), .NUM_OF_ROWS(128), .NUM_OF_COLS(8),
        .T_RCD(3), .T_CL(2), .T_WR(2), .T_RP(3),
        .REFRESH_INTERVAL(RI), .T_RFC(8)
    ) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] row_oh(input int i);
        logic [127:0] one;
        one = 128'd1;
        return one << i;
    endfunction

    // Issue one command and run the full handshake. exp_lat is the number of
    // edges from the accepting edge to the ack edge (-1 = don't check).
    // early=1 raises the request right after the ack-fall edge (RELEASE).
    task automatic do_cmd(input string tag, input logic [1:0] c, input logic [7:0] bs,
                          input logic [127:0] rs, input logic [7:0] cs, input logic wd,
                          input int exp_lat, input logic exp_err, input bit early);
        int  n;
        bit  got;
        if (!early) @(negedge clk);
        bus.cmd      = c;
        bus.bank_sel = bs;
        bus.row_sel  = rs;
        bus.col_sel  = cs;
        bus.wr_data  = wd;
        bus.cmd_req  = 1'b1;
        n   = 0;
        got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.cmd_ack) got = 1;
            else if (n == (early ? 2 : 1)) begin
                // operands are latched; disturb the bus while the command runs
                bus.bank_sel = 8'hFF;
                bus.col_sel  = 8'h00;
                bus.row_sel  = '0;
                bus.wr_data  = ~wd;
                bus.cmd      = ~c;
            end
        end
        chk({tag, "_ack"}, 32'(got), 32'd1);
        if (exp_lat >= 0) chk({tag, "_lat"}, 32'(n - 1), 32'(exp_lat));
        chk({tag, "_err"}, 32'(bus.cmd_err), 32'(exp_err));
        $display("txn %s cmd=%0d bank=%0h lat=%0d err=%0b rd=%0b", tag, c, bs, n - 1,
                 bus.cmd_err, bus.rd_data);
        bus.cmd_req = 1'b0;
        @(negedge clk);
        chk({tag, "_ackfall"}, 32'(bus.cmd_ack), 32'd0);
        chk({tag, "_errclr"}, 32'(bus.cmd_err), 32'd0);
    endtask

    initial begin
        int w;
        int nb;
        int hi;
        rst_b        = 1'b0;
        bus.cmd_req  = 1'b0;
        bus.cmd      = 2'b00;
        bus.bank_sel = '0;
        bus.row_sel  = '0;
        bus.col_sel  = '0;
        bus.wr_data  = 1'b0;
        #23;
        chk("rst_ack", 32'(bus.cmd_ack), 0);
        chk("rst_rd",  32'(bus.rd_data), 0);
        chk("rst_err", 32'(bus.cmd_err), 0);
        chk("rst_rfb", 32'(bus.refresh_busy), 0);
        @(negedge clk);
        rst_b = 1'b1;

`ifndef DRAM_REFRESH_EN
        // basic ACTIVATE / WRITE / READ on bank 2 row 5
        do_cmd("act_b2",    ACT, 8'h04, row_oh(5), 8'h00, 1'b0, 4, 1'b0, 0);
        do_cmd("wr_c3",     WR,  8'h04, '0,        8'h08, 1'b1, 3, 1'b0, 0);
        do_cmd("rd_c3",     RD,  8'h04, '0,        8'h08, 1'b0, 3, 1'b0, 0);
        chk("rd_c3_data", 32'(bus.rd_data), 1);
        // error: READ of a closed bank, rd_data must hold its value
        do_cmd("rd_closed", RD,  8'h40, '0,        8'h08, 1'b0, 2, 1'b1, 0);
        chk("rd_closed_hold", 32'(bus.rd_data), 1);
        do_cmd("wr_c4",     WR,  8'h04, '0,        8'h10, 1'b0, 3, 1'b0, 0);
        do_cmd("rd_c4",     RD,  8'h04, '0,        8'h10, 1'b1, 3, 1'b0, 0);
        chk("rd_c4_data", 32'(bus.rd_data), 0);
        // non-one-hot bank select opens nothing
        do_cmd("act_b01",   ACT, 8'h03, row_oh(5), 8'h00, 1'b0, 2, 1'b1, 0);
        do_cmd("rd_b0",     RD,  8'h01, '0,        8'h01, 1'b0, 2, 1'b1, 0);
        do_cmd("rd_badcol", RD,  8'h04, '0,        8'h18, 1'b0, 2, 1'b1, 0);
        // double ACTIVATE / double PRECHARGE of bank 1
        do_cmd("act_b1a",   ACT, 8'h02, row_oh(7), 8'h00, 1'b0, 4, 1'b0, 0);
        do_cmd("act_b1b",   ACT, 8'h02, row_oh(9), 8'h00, 1'b0, 2, 1'b1, 0);
        do_cmd("pre_b1a",   PRE, 8'h02, '0,        8'h00, 1'b0, 4, 1'b0, 0);
        do_cmd("pre_b1b",   PRE, 8'h02, '0,        8'h00, 1'b0, 4, 1'b0, 0);
        do_cmd("rd_b1",     RD,  8'h02, '0,        8'h01, 1'b0, 2, 1'b1, 0);

        // reset while a WRITE of 0 to b2/r5/c3 is in BUSY
        @(negedge clk);
        bus.cmd = WR; bus.bank_sel = 8'h04; bus.col_sel = 8'h08; bus.wr_data = 1'b0;
        bus.cmd_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        chk("rstbusy_ack", 32'(bus.cmd_ack), 0);
        chk("rstbusy_rd",  32'(bus.rd_data), 0);
        $display("txn rst_in_busy ack=%0b", bus.cmd_ack);
        bus.cmd_req = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        do_cmd("act_b2r",   ACT, 8'h04, row_oh(5), 8'h00, 1'b0, 4, 1'b0, 0);
        do_cmd("rd_c3r",    RD,  8'h04, '0,        8'h08, 1'b0, 3, 1'b0, 0);
        chk("rd_c3r_data", 32'(bus.rd_data), 1);

        // request dropped before ack: exactly one ack cycle
        @(negedge clk);
        bus.cmd = PRE; bus.bank_sel = 8'h04; bus.cmd_req = 1'b1;
        @(negedge clk);
        bus.cmd_req = 1'b0;
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.cmd_ack) begin
                hi++;
                chk("short_err", 32'(bus.cmd_err), 0);
            end
        end
        chk("short_pulse", 32'(hi), 1);
        $display("txn short_req ack_cycles=%0d", hi);
        do_cmd("rd_b2pre",  RD,  8'h04, '0,        8'h08, 1'b0, 2, 1'b1, 0);

        // request raised during RELEASE waits for IDLE (one extra edge)
        do_cmd("act_b3",    ACT, 8'h08, row_oh(0), 8'h00, 1'b0, 4, 1'b0, 0);
        do_cmd("wr_early",  WR,  8'h08, '0,        8'h01, 1'b1, 4, 1'b0, 1);
        do_cmd("rd_b3",     RD,  8'h08, '0,        8'h01, 1'b0, 3, 1'b0, 0);
        chk("rd_b3_data", 32'(bus.rd_data), 1);

        // reset while ack is high drops it asynchronously
        @(negedge clk);
        bus.cmd = PRE; bus.bank_sel = 8'h08; bus.cmd_req = 1'b1;
        w = 0;
        while (!bus.cmd_ack && w < 40) begin @(negedge clk); w++; end
        chk("rstack_seen", 32'(bus.cmd_ack), 1);
        #2 rst_b = 1'b0;
        #1;
        chk("rstack_drop", 32'(bus.cmd_ack), 0);
        $display("txn rst_in_ack ack=%0b", bus.cmd_ack);
        bus.cmd_req = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        do_cmd("rd_b3rst",  RD,  8'h08, '0,        8'h01, 1'b0, 2, 1'b1, 0);
        chk("rfb_off", 32'(bus.refresh_busy), 0);
`else
        // line up just after a refresh, open bank 2, then hit the next refresh
        w = 0;
        while (!bus.refresh_busy && w < 64) begin @(negedge clk); w++; end
        chk("rf1_seen", 32'(bus.refresh_busy), 1);
        w = 0;
        while (bus.refresh_busy && w < 64) begin @(negedge clk); w++; end
        chk("rf1_end", 32'(bus.refresh_busy), 0);
        do_cmd("rf_act", ACT, 8'h04, row_oh(5), 8'h00, 1'b0, -1, 1'b0, 0);
        w = 0;
        while (!bus.refresh_busy && w < 64) begin @(negedge clk); w++; end
        chk("rf2_seen", 32'(bus.refresh_busy), 1);
        bus.cmd = RD; bus.bank_sel = 8'h04; bus.col_sel = 8'h08; bus.cmd_req = 1'b1;
        nb = 1;
        w  = 0;
        while (bus.refresh_busy && w < 64) begin
            @(negedge clk);
            w++;
            if (bus.refresh_busy) begin
                nb++;
                chk("rf_hold_ack", 32'(bus.cmd_ack), 0);
            end
        end
        chk("rf_len", 32'(nb), 8);
        w = 0;
        while (!bus.cmd_ack && w < 40) begin @(negedge clk); w++; end
        chk("rf_rd_ack", 32'(bus.cmd_ack), 1);
        chk("rf_rd_err", 32'(bus.cmd_err), 1);
        $display("txn rf_read busy_cycles=%0d err=%0b", nb, bus.cmd_err);
        bus.cmd_req = 1'b0;
        @(negedge clk);
        chk("rf_ackfall", 32'(bus.cmd_ack), 0);
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end
endmodule
